bcd_seq_adder: RTL and testbench
================================

# bcd_seq_adder

Digit-serial, multi-digit packed-BCD adder/subtractor. It processes one decimal digit per clock, least-significant first, behind a start/done handshake. It is the parametrised successor of the single-digit combinational BCD adder and serves as the arithmetic unit for the multi-digit display/counter datapaths. Input validity is checked in hardware and reported as a sticky flag, not as a simulation message.

## Interface

Parameters:
- DIGITS, default 4: number of BCD digits per operand; legal range ≥1.

Ports:
- clk, in, 1: single system clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- start_valid, in, 1: operation request.
- start_ready, out, 1: block can accept a request. High only in IDLE.
- a, in, 4*DIGITS: operand A, packed BCD, digit 0 in bits [3:0].
- b, in, 4*DIGITS: operand B, packed BCD.
- sub, in, 1: 1 selects A−B. Honoured only with BCD_SUB_EN.
- sum, out, 4*DIGITS: result, packed BCD. Registered.
- carry_out, out, 1: decimal carry from the top digit. In subtract mode, 1 means no borrow.
- invalid, out, 1: at least one operand nibble was >9 in the last operation.
- done, out, 1: one-cycle pulse; sum, carry_out and invalid are valid.
- busy, out, 1: high in RUN and DONE.

Reset and clock are fixed: one clock, asynchronous active-low reset.

## Operation

- FSM states: IDLE → RUN → DONE → IDLE.
- Accept happens when start_valid && start_ready. At accept, the block captures a, b and sub, sets digit index = 0, sets the carry register = sub_eff, clears the invalid accumulator, and enters RUN.
- While the FSM is not in IDLE, start_valid is ignored. No queuing.
- Each RUN cycle, for digit i:
  - b_i' = sub_eff ? 9−b_i : b_i.
  - raw = a_i + b_i' + c, computed 5 bits wide.
  - If raw > 9: digit = (raw + 6)[3:0] and c = 1. Otherwise digit = raw[3:0] and c = 0.
  - If a_i > 9 or b_i > 9, set the invalid accumulator. The digit is still computed by the same rule.
  - For subtraction, the 9−b_i term uses a 4-bit wrap.
- After digit DIGITS−1, the block loads sum, carry_out and invalid from the working registers in one step and enters DONE. The sum output never shows partial results.
- DONE lasts exactly one cycle with done=1, then the FSM returns to IDLE.
- sum, carry_out and invalid hold their values until the next operation completes.
- Subtraction result, A ≥ B: sum = A−B, carry_out = 1.
- Subtraction result, A < B: sum = 10^DIGITS − (B−A) (ten's complement), carry_out = 0.

## Timing

- Accept at rising edge k. Digits 0 to DIGITS−1 are computed at edges k+1 to k+DIGITS.
- Outputs update at edge k+DIGITS, and done is high during the cycle after that edge.
- Latency from accept edge to done: DIGITS edges.
- start_ready returns high after edge k+DIGITS+1.
- Back-to-back throughput: one operation per DIGITS+2 cycles.
- Reset (asynchronous, any state) forces:
  - state = IDLE;
  - sum, carry_out, invalid, done and busy = 0;
  - start_ready = 1.
- Reset mid-operation aborts the operation with no done pulse.
- A start_valid that coincides with reset deassertion is accepted only at the first edge with rst_n high.
- DIGITS = 1: RUN lasts one cycle.

## Configuration

- BCD_SUB_EN defined: subtract mode is included, with sub_eff = the captured sub. Adds the nine's-complement mux and carry-in preset.
- BCD_SUB_EN undefined: sub_eff = 0. The sub port exists but is ignored, and there is no complement logic.

## Structure

- Package bcd_pkg holds:
  - typedef bcd_digit_t (4 bits);
  - the FSM state enum;
  - constants BCD_MAX = 9 and BCD_ADJ = 6.
- Sub-module bcd_digit_add is combinational. Inputs: a_i, b_i', c. Outputs: digit, c_out, nib_invalid.
- The top level holds the FSM, the digit counter, and the operand and result shift registers.

## Test plan

- DIGITS=4, add: a=0x1234, b=0x5678, accept at edge k → at edge k+4, sum=0x6912, carry_out=0, invalid=0, done pulses once.
- Add with full carry chain: a=0x9999, b=0x0001 → sum=0x0000, carry_out=1.
- BCD_SUB_EN, sub=1:
  - 0x5000−0x1234 → sum=0x3766, carry_out=1.
  - 0x1234−0x5000 → sum=0x6234, carry_out=0.
- Invalid input: a=0x00A0, b=0x0001 → invalid=1 at done. A following valid operation clears it to 0.
- Reset: assert rst_n=0 two cycles after accept → done never pulses, all outputs 0, start_ready=1 immediately.
- Handshake:
  - start_valid held high continuously → second accept one cycle after the done cycle.
  - DIGITS=1, 9+9 → sum=0x8, carry_out=1 one edge after accept.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder/subtractor.
// Optional subtract support is controlled by the BCD_SUB_EN macro (see bcd_seq_adder).
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_ADJ = 4'd6;

    // Nine's complement of one digit, wrapping in 4 bits so that illegal
    // nibbles (10..15) stay illegal after complementing.
    function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
        return bcd_digit_t'(BCD_MAX - d);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit combinational BCD add cell with decimal carry and a flag for
// operand nibbles outside 0..9.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t a_i,
    input  bcd_digit_t b_i,
    input  logic       c,
    output bcd_digit_t digit,
    output logic       c_out,
    output logic       nib_invalid
);

    logic [4:0] raw;
    bcd_digit_t adj;

    // Binary sum, then +6 correction whenever the digit overflows past nine.
    always_comb begin
        raw         = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, c};
        adj         = raw[3:0] + BCD_ADJ;
        digit       = raw[3:0];
        c_out       = 1'b0;
        if (raw > {1'b0, BCD_MAX}) begin
            digit = adj;
            c_out = 1'b1;
        end
        nib_invalid = (a_i > BCD_MAX) || (b_i > BCD_MAX);
    end

endmodule

// File: rtl/bcd_seq_adder.sv
// Digit-serial packed-BCD adder, one digit per clock, least significant first,
// behind a start/done handshake. Define BCD_SUB_EN to include subtract mode
// (nine's complement of B with carry-in preset to 1); without it the sub input
// is ignored.
module bcd_seq_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                sub,
    output logic [4*DIGITS-1:0] sum,
    output logic                carry_out,
    output logic                invalid,
    output logic                done,
    output logic                busy
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t         state;
    logic [W-1:0]   a_sr;
    logic [W-1:0]   b_sr;
    logic [W-1:0]   res_sr;
    logic [W-1:0]   res_next;
    logic [CW-1:0]  idx;
    logic           carry;
    logic           inv_acc;
    logic           sub_eff;
    logic           last_digit;
    bcd_digit_t     b_eff;
    bcd_digit_t     digit;
    logic           c_out;
    logic           nib_invalid;

`ifdef BCD_SUB_EN
    logic           sub_reg;

    // Subtraction adds the nine's complement of each B digit.
    always_comb begin
        sub_eff = sub_reg;
        b_eff   = sub_reg ? nines_comp(b_sr[3:0]) : b_sr[3:0];
    end
`else
    // Subtract mode is not built; the sub port is deliberately left unconnected.
    logic unused_sub;
    assign unused_sub = sub;

    always_comb begin
        sub_eff = 1'b0;
        b_eff   = b_sr[3:0];
    end
`endif

    bcd_digit_add u_digit (
        .a_i        (a_sr[3:0]),
        .b_i        (b_eff),
        .c          (carry),
        .digit      (digit),
        .c_out      (c_out),
        .nib_invalid(nib_invalid)
    );

    // New digit enters at the top of the result register; after DIGITS shifts
    // digit 0 has reached the bottom nibble.
    always_comb begin
        res_next   = (res_sr >> 4) | (W'(digit) << (4 * (DIGITS - 1)));
        last_digit = (idx == CW'(DIGITS - 1));
    end

    // Handshake FSM, digit counter, operand/result shift registers and
    // registered outputs, all advanced together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            a_sr        <= '0;
            b_sr        <= '0;
            res_sr      <= '0;
            idx         <= '0;
            carry       <= 1'b0;
            inv_acc     <= 1'b0;
`ifdef BCD_SUB_EN
            sub_reg     <= 1'b0;
`endif
            sum         <= '0;
            carry_out   <= 1'b0;
            invalid     <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start_valid && start_ready) begin
                        a_sr        <= a;
                        b_sr        <= b;
                        idx         <= '0;
`ifdef BCD_SUB_EN
                        sub_reg     <= sub;
                        carry       <= sub;
`else
                        carry       <= sub_eff;
`endif
                        inv_acc     <= 1'b0;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sr    <= a_sr >> 4;
                    b_sr    <= b_sr >> 4;
                    res_sr  <= res_next;
                    carry   <= c_out;
                    inv_acc <= inv_acc | nib_invalid;
                    idx     <= idx + CW'(1);
                    if (last_digit) begin
                        sum       <= res_next;
                        carry_out <= c_out;
                        invalid   <= inv_acc | nib_invalid;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_seq_adder.sv
// Scoreboard bench for bcd_seq_adder: a 4-digit instance and a 1-digit instance.
// Subtract vectors are exercised only when BCD_SUB_EN is defined.
module tb_bcd_seq_adder;

    typedef struct {
        logic [15:0] sum;
        logic        c;
        logic        inv;
        int          acc;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          cyc;
    int          checks;
    int          errors;

    logic        sv4, sub4, ready4, c4, inv4, done4, busy4;
    logic [15:0] a4, b4, sum4;
    logic        sv1, sub1, ready1, c1, inv1, done1, busy1;
    logic [3:0]  a1, b1, sum1;

    exp_t sb4[$];
    exp_t sb1[$];

    bcd_seq_adder #(.DIGITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv4), .start_ready(ready4),
        .a(a4), .b(b4), .sub(sub4), .sum(sum4), .carry_out(c4),
        .invalid(inv4), .done(done4), .busy(busy4)
    );

    bcd_seq_adder #(.DIGITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(ready1),
        .a(a1), .b(b1), .sub(sub1), .sum(sum1), .carry_out(c1),
        .invalid(inv1), .done(done1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Drive one request and record its expected result on the matching scoreboard.
    task automatic apply_stimulus(input bit one_digit, input logic [15:0] a_v, input logic [15:0] b_v,
                                  input logic sub_v, input logic [15:0] e_sum, input logic e_c,
                                  input logic e_inv, input string name, input bit hold,
                                  output int acc);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        if (one_digit) begin
            a1 = a_v[3:0]; b1 = b_v[3:0]; sub1 = sub_v; sv1 = 1'b1;
        end else begin
            a4 = a_v; b4 = b_v; sub4 = sub_v; sv4 = 1'b1;
        end
        while (!(one_digit ? ready1 : ready4) && n < 100) begin
            @(negedge clk);
            n++;
        end
        acc = cyc + 1;
        if (n >= 100) begin
            check_output({name, "_ready_timeout"}, 16'd0, 16'd1);
        end else begin
            e.sum = e_sum; e.c = e_c; e.inv = e_inv; e.acc = acc; e.name = name;
            if (one_digit) sb1.push_back(e);
            else           sb4.push_back(e);
        end
        @(posedge clk);
        if (!hold) begin
            #1;
            sv1 = 1'b0;
            sv4 = 1'b0;
        end
    endtask

    // Monitor for the 4-digit instance: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done4) begin
            if (sb4.size() == 0) begin
                check_output("dut4_unexpected_done", 16'd1, 16'd0);
            end else begin
                e = sb4.pop_front();
                check_output({e.name, "_sum"}, sum4, e.sum);
                check_output({e.name, "_carry"}, {15'd0, c4}, {15'd0, e.c});
                check_output({e.name, "_invalid"}, {15'd0, inv4}, {15'd0, e.inv});
                check_output({e.name, "_latency"}, 16'(cyc - e.acc), 16'd4);
                check_output({e.name, "_busy_ready"}, {14'd0, busy4, ready4}, 16'b10);
            end
        end
    end

    // Monitor for the 1-digit instance.
    always @(negedge clk) begin
        exp_t e;
        if (done1) begin
            if (sb1.size() == 0) begin
                check_output("dut1_unexpected_done", 16'd1, 16'd0);
            end else begin
                e = sb1.pop_front();
                check_output({e.name, "_sum"}, {12'd0, sum1}, e.sum);
                check_output({e.name, "_carry"}, {15'd0, c1}, {15'd0, e.c});
                check_output({e.name, "_invalid"}, {15'd0, inv1}, {15'd0, e.inv});
                check_output({e.name, "_latency"}, 16'(cyc - e.acc), 16'd1);
            end
        end
    end

    initial begin
        int acc_a;
        int acc_b;
        int n;
        cyc = 0; checks = 0; errors = 0;
        rst_n = 1'b0;
        sv4 = 1'b0; a4 = '0; b4 = '0; sub4 = 1'b0;
        sv1 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_output("rst_ready4", {15'd0, ready4}, 16'd1);
        check_output("rst_outs4", {sum4[12:0], c4, inv4, done4}, 16'd0);
        check_output("rst_busy4", {15'd0, busy4}, 16'd0);
        check_output("rst_ready1", {15'd0, ready1}, 16'd1);
        check_output("rst_outs1", {sum1, c1, inv1, done1, busy1}, 16'd0);
        rst_n = 1'b1;

        // Plain additions
        apply_stimulus(1'b0, 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, "add_1234_5678", 1'b0, acc_a);
        apply_stimulus(1'b0, 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "add_carry_chain", 1'b0, acc_a);
        apply_stimulus(1'b0, 16'h9999, 16'h9999, 1'b0, 16'h9998, 1'b1, 1'b0, "add_max", 1'b0, acc_a);
        apply_stimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, "add_zero", 1'b0, acc_a);

`ifdef BCD_SUB_EN
        apply_stimulus(1'b0, 16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b1, 1'b0, "sub_a_ge_b", 1'b0, acc_a);
        apply_stimulus(1'b0, 16'h1234, 16'h5000, 1'b1, 16'h6234, 1'b0, 1'b0, "sub_a_lt_b", 1'b0, acc_a);
        apply_stimulus(1'b0, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, "sub_small", 1'b0, acc_a);
        apply_stimulus(1'b1, 16'h0003, 16'h0004, 1'b1, 16'h0009, 1'b0, 1'b0, "d1_sub_3_4", 1'b0, acc_a);
`else
        apply_stimulus(1'b0, 16'h0005, 16'h0003, 1'b1, 16'h0008, 1'b0, 1'b0, "sub_ignored", 1'b0, acc_a);
`endif

        // Invalid nibble sets the flag; the next clean operation clears it
        apply_stimulus(1'b0, 16'h00A0, 16'h0001, 1'b0, 16'h0101, 1'b0, 1'b1, "invalid_a", 1'b0, acc_a);
        apply_stimulus(1'b0, 16'h0042, 16'h0058, 1'b0, 16'h0100, 1'b0, 1'b0, "invalid_cleared", 1'b0, acc_a);

        // Back-to-back with start_valid held high
        apply_stimulus(1'b0, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, "b2b_first", 1'b1, acc_a);
        apply_stimulus(1'b0, 16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0, "b2b_second", 1'b0, acc_b);
        check_output("b2b_accept_gap", 16'(acc_b - acc_a), 16'd6);

        // Single-digit instance
        apply_stimulus(1'b1, 16'h0009, 16'h0009, 1'b0, 16'h0008, 1'b1, 1'b0, "d1_9_plus_9", 1'b0, acc_a);
        apply_stimulus(1'b1, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, "d1_3_plus_4", 1'b0, acc_a);

        // Let pending results drain before the abort test
        n = 0;
        while ((sb4.size() != 0 || sb1.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end

        // Reset two cycles after accept: aborts with no done pulse
        @(negedge clk);
        a4 = 16'h1111; b4 = 16'h2222; sub4 = 1'b0; sv4 = 1'b1;
        @(posedge clk);
        #1 sv4 = 1'b0;
        check_output("abort_busy_before", {15'd0, busy4}, 16'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_output("abort_ready", {15'd0, ready4}, 16'd1);
        check_output("abort_sum", sum4, 16'h0000);
        check_output("abort_flags", {12'd0, c4, inv4, done4, busy4}, 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_output("abort_sum_after", sum4, 16'h0000);

        // Operation after reset recovery
        apply_stimulus(1'b0, 16'h0250, 16'h0750, 1'b0, 16'h1000, 1'b0, 1'b0, "post_reset_add", 1'b0, acc_a);

        n = 0;
        while ((sb4.size() != 0 || sb1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_output("scoreboard_drained", 16'(sb4.size() + sb1.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
